lib_countdown_timer: RTL and testbench

LIB_COUNTDOWN_TIMER -- requirements
Module: lib_countdown_timer

---
 rtl/lib_countdown_pkg.sv | 12 +
 rtl/lib_sync_ff.sv | 20 ++
 rtl/lib_countdown_timer.sv | 108 ++++++++++
 tb/tb_lib_countdown_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lib_countdown_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding and default width.
package lib_countdown_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lib_sync_ff.sv
// Generic W-bit register with synchronous active-high reset to zero.
module lib_sync_ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/lib_countdown_timer.sv
// Loadable countdown timer with one-shot or auto-reload operation.
// Auto-reload is compiled in only when COUNTDOWN_AUTORELOAD_EN is defined.
module lib_countdown_timer
    import lib_countdown_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          start,
    input  logic          stop,
    input  logic          ce,
    input  logic          auto_rl,
    output logic          busy,
    output logic          uf,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] rl_q;
    logic [DW-1:0] rl_d;
    logic [1:0]    state_bits;
    state_t        state_q;
    state_t        state_d;
    logic [DW:0]   cnt_q;
    logic [DW:0]   cnt_d;
    logic [DW-1:0] dout_d;
    logic          uf_d;
    logic          auto_en;

`ifdef COUNTDOWN_AUTORELOAD_EN
    assign auto_en = auto_rl;
`else
    logic unused_auto_rl;
    assign unused_auto_rl = auto_rl;
    assign auto_en        = 1'b0;
`endif

    assign state_q = state_t'(state_bits);
    assign uf      = cnt_q[DW];
    assign dout    = cnt_q[DW-1:0];
    assign busy    = (state_q == ST_RUN);

    // A write in the same cycle as start is visible to that start (bypass).
    assign rl_d = we ? din : rl_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        dout_d  = dout;
        uf_d    = uf;
        if (stop) begin
            state_d = ST_IDLE;
            uf_d    = 1'b0;
        end else if (start) begin
            if (rl_d != '0) begin
                state_d = ST_RUN;
                dout_d  = rl_d;
                uf_d    = 1'b0;
            end else if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                uf_d    = 1'b0;
            end
        end else if (state_q == ST_RUN && ce) begin
            if (dout > DW'(1)) begin
                dout_d = dout - DW'(1);
            end else if (dout == DW'(1)) begin
                dout_d  = '0;
                uf_d    = 1'b1;
                state_d = auto_en ? ST_RUN : ST_DONE;
            end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                // Zero cycle of an auto-reload period: reload from the stored value.
                dout_d = rl_q;
                uf_d   = 1'b0;
                if (rl_q == '0) begin
                    state_d = ST_IDLE;
                end
`endif
            end
        end
    end

    assign cnt_d = {uf_d, dout_d};

    lib_sync_ff #(.W(DW)) u_rl_ff (
        .clk (clk),
        .rst (rst),
        .d   (rl_d),
        .q   (rl_q)
    );

    lib_sync_ff #(.W(2)) u_state_ff (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_bits)
    );

    lib_sync_ff #(.W(DW + 1)) u_cnt_ff (
        .clk (clk),
        .rst (rst),
        .d   (cnt_d),
        .q   (cnt_q)
    );

endmodule

// File: tb/tb_lib_countdown_timer.sv
// Directed bench for lib_countdown_timer; the auto-reload sequence depends on COUNTDOWN_AUTORELOAD_EN.
module tb_lib_countdown_timer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [DW-1:0] din;
    logic          start;
    logic          stop;
    logic          ce;
    logic          auto_rl;
    logic          busy;
    logic          uf;
    logic [DW-1:0] dout;

    int pass_cnt = 0;
    int total    = 0;

    lib_countdown_timer #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .din     (din),
        .start   (start),
        .stop    (stop),
        .ce      (ce),
        .auto_rl (auto_rl),
        .busy    (busy),
        .uf      (uf),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input int e_dout, input bit e_uf, input bit e_busy);
        chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
        chk({tag, ".uf"},   32'(uf),   32'(e_uf));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; din = '0; start = 1'b0; stop = 1'b0; ce = 1'b0; auto_rl = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 0, 0, 0);

        // Start with reload value zero: stays idle.
        start = 1'b1;
        tick();
        chk_out("start_rl0", 0, 0, 0);
        start = 1'b0;

        // One-shot 3,2,1,0 then DONE ignores ce.
        we = 1'b1; din = 16'd3;
        tick();
        we = 1'b0; start = 1'b1; ce = 1'b1;
        tick();
        chk_out("os3", 3, 0, 1);
        start = 1'b0;
        tick();
        chk_out("os2", 2, 0, 1);
        tick();
        chk_out("os1", 1, 0, 1);
        tick();
        chk_out("os0", 0, 1, 0);
        tick();
        chk_out("done_hold", 0, 1, 0);

        // Restart from DONE with same-cycle write bypass.
        ce = 1'b0; start = 1'b1; we = 1'b1; din = 16'd5;
        tick();
        chk_out("bypass5", 5, 0, 1);
        // Write during RUN must not disturb the count.
        start = 1'b0; we = 1'b1; din = 16'd9; ce = 1'b1;
        tick();
        chk_out("we_in_run", 4, 0, 1);
        we = 1'b0;

        // Reset mid-count with ce high.
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 0, 0, 0);
        rst = 1'b0; ce = 1'b0; start = 1'b1;
        tick();
        chk_out("rst_rl_clear", 0, 0, 0);
        start = 1'b0;

        // Stop wins over start at dout=7.
        we = 1'b1; din = 16'd9; start = 1'b1;
        tick();
        chk_out("load9", 9, 0, 1);
        we = 1'b0; start = 1'b0; ce = 1'b1;
        tick();
        tick();
        chk_out("cnt7", 7, 0, 1);
        ce = 1'b0; stop = 1'b1; start = 1'b1;
        tick();
        chk_out("stop_start", 7, 0, 0);
        stop = 1'b0; start = 1'b0;
        tick();
        chk_out("stop_hold", 7, 0, 0);

        // Stop from DONE clears uf.
        we = 1'b1; din = 16'd1; start = 1'b1;
        tick();
        chk_out("load1", 1, 0, 1);
        we = 1'b0; start = 1'b0; ce = 1'b1;
        tick();
        chk_out("done1", 0, 1, 0);
        stop = 1'b1;
        tick();
        chk_out("stop_done", 0, 0, 0);
        stop = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload with rl_val=2: 2,1,0,2,1,0.
        we = 1'b1; din = 16'd2; start = 1'b1; auto_rl = 1'b1; ce = 1'b1;
        tick();
        chk_out("ar_2a", 2, 0, 1);
        we = 1'b0; start = 1'b0;
        tick();
        chk_out("ar_1a", 1, 0, 1);
        tick();
        chk_out("ar_0a", 0, 1, 1);
        tick();
        chk_out("ar_2b", 2, 0, 1);
        tick();
        chk_out("ar_1b", 1, 0, 1);
        tick();
        chk_out("ar_0b", 0, 1, 1);
        // Expiry already committed to RUN; reload still happens, next expiry is one-shot.
        auto_rl = 1'b0;
        tick();
        chk_out("ar_2c", 2, 0, 1);
        tick();
        tick();
        chk_out("ar_done", 0, 1, 0);
        // Reload value cleared mid-run: zero-cycle reload returns to IDLE.
        auto_rl = 1'b1; start = 1'b1;
        tick();
        chk_out("ar_re2", 2, 0, 1);
        start = 1'b0; we = 1'b1; din = 16'd0;
        tick();
        chk_out("ar_re1", 1, 0, 1);
        we = 1'b0;
        tick();
        chk_out("ar_re0", 0, 1, 1);
        tick();
        chk_out("ar_idle", 0, 0, 0);
`else
        // Without auto-reload support, auto_rl is ignored: one-shot.
        we = 1'b1; din = 16'd2; start = 1'b1; auto_rl = 1'b1; ce = 1'b1;
        tick();
        chk_out("na_2", 2, 0, 1);
        we = 1'b0; start = 1'b0;
        tick();
        chk_out("na_1", 1, 0, 1);
        tick();
        chk_out("na_0", 0, 1, 0);
        tick();
        chk_out("na_hold", 0, 1, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
